// File: rtl/multi_stage.sv
// Sequential multiply stage: accepts operand pairs, multiplies by shift-add and writes
// the low 32 product bits to a FIFO. Define MULTI_RADIX4_EN for radix-4 (16-step) multiplication.
module multi_stage #(
    parameter int N_PROD = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        multi_opstart,
    input  logic        multi_opclear,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        fifo_full,
    output logic        fifo_we,
    output logic [31:0] fifo_din,
    output logic [3:0]  prod_count,
    output logic        multi_opdone
);

`ifdef MULTI_RADIX4_EN
    localparam int STEPS = 16;
`else
    localparam int STEPS = 32;
`endif
    localparam logic [4:0] STEP_LAST   = 5'(STEPS - 1);
    localparam logic [3:0] N_PROD_LAST = 4'(N_PROD);

    typedef enum logic [2:0] {IDLE, LOAD, CALC, WRITE, DONE} state_t;

    state_t      state_reg, state_next;
    logic [31:0] mcand_reg, mplier_reg, acc_reg;
    logic [4:0]  step_reg;
    logic        op_ready_reg, op_ready_next;
    logic        fifo_we_reg, fifo_we_next;
    logic [31:0] fifo_din_reg, fifo_din_next;
    logic [3:0]  prod_count_reg, prod_count_next;
    logic        done_reg, done_next;

    logic        abort;
    logic        accept;
    logic        write_now;
    logic [3:0]  pc_inc;
    logic [31:0] addend;

    // Abort covers both the explicit clear and dropping the job enable mid-job.
    assign abort     = multi_opclear || (!multi_opstart && state_reg != IDLE);
    assign accept    = (state_reg == LOAD) && op_valid && !abort;
    assign write_now = (state_reg == WRITE) && !fifo_full && !abort;
    assign pc_inc    = (prod_count_reg == N_PROD_LAST) ? prod_count_reg : prod_count_reg + 4'd1;

`ifdef MULTI_RADIX4_EN
    always_comb begin
        addend = '0;
        case (mplier_reg[1:0])
            2'd0: addend = '0;
            2'd1: addend = mcand_reg;
            2'd2: addend = mcand_reg << 1;
            2'd3: addend = mcand_reg + (mcand_reg << 1);
            default: addend = '0;
        endcase
    end
`else
    assign addend = mplier_reg[0] ? mcand_reg : 32'd0;
`endif

    // State register plus registered outputs and multiplier datapath.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            acc_reg        <= '0;
            step_reg       <= '0;
            op_ready_reg   <= 1'b0;
            fifo_we_reg    <= 1'b0;
            fifo_din_reg   <= '0;
            prod_count_reg <= '0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            op_ready_reg   <= op_ready_next;
            fifo_we_reg    <= fifo_we_next;
            fifo_din_reg   <= fifo_din_next;
            prod_count_reg <= prod_count_next;
            done_reg       <= done_next;
            if (accept) begin
                mcand_reg  <= op_a;
                mplier_reg <= op_b;
                acc_reg    <= '0;
                step_reg   <= '0;
            end else if (state_reg == CALC && !abort) begin
                acc_reg  <= acc_reg + addend;
`ifdef MULTI_RADIX4_EN
                mcand_reg  <= mcand_reg << 2;
                mplier_reg <= mplier_reg >> 2;
`else
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
`endif
                step_reg <= step_reg + 5'd1;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:  if (multi_opstart) state_next = LOAD;
                LOAD:  if (op_valid) state_next = CALC;
                CALC:  if (step_reg == STEP_LAST) state_next = WRITE;
                WRITE: if (!fifo_full) state_next = (pc_inc == N_PROD_LAST) ? DONE : LOAD;
                DONE:  state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        op_ready_next   = (state_next == LOAD);
        done_next       = (state_next == DONE);
        fifo_we_next    = write_now;
        fifo_din_next   = write_now ? acc_reg : fifo_din_reg;
        prod_count_next = prod_count_reg;
        if (abort)
            prod_count_next = '0;
        else if (write_now)
            prod_count_next = pc_inc;
    end

    assign op_ready     = op_ready_reg;
    assign fifo_we      = fifo_we_reg;
    assign fifo_din     = fifo_din_reg;
    assign prod_count   = prod_count_reg;
    assign multi_opdone = done_reg;

endmodule

// File: tb/tb_multi_stage.sv
// Directed self-checking bench for multi_stage; honours MULTI_RADIX4_EN for expected latency.
module tb_multi_stage;

`ifdef MULTI_RADIX4_EN
    localparam int LAT = 17;
`else
    localparam int LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        multi_opstart;
    logic        multi_opclear;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_valid;
    logic        op_ready;
    logic        fifo_full;
    logic        fifo_we;
    logic [31:0] fifo_din;
    logic [3:0]  prod_count;
    logic        multi_opdone;

    int checks = 0;
    int errors = 0;

    multi_stage #(.N_PROD(8)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .multi_opstart(multi_opstart),
        .multi_opclear(multi_opclear),
        .op_a(op_a),
        .op_b(op_b),
        .op_valid(op_valid),
        .op_ready(op_ready),
        .fifo_full(fifo_full),
        .fifo_we(fifo_we),
        .fifo_din(fifo_din),
        .prod_count(prod_count),
        .multi_opdone(multi_opdone)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!op_ready && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_ready"}, {31'd0, op_ready}, 32'd1);
    endtask

    task automatic accept(input logic [31:0] a, input logic [31:0] b);
        op_a = a;
        op_b = b;
        op_valid = 1'b1;
        tick();
        op_valid = 1'b0;
    endtask

    // Runs one product through: checks latency, value and count.
    task automatic do_job(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input logic [3:0] exp_pc);
        int n;
        wait_ready(tag);
        accept(a, b);
        n = 0;
        while (n < 100) begin
            tick();
            n++;
            if (fifo_we) break;
        end
        check({tag, "_lat"}, n, LAT);
        check({tag, "_din"}, fifo_din, exp);
        check({tag, "_pc"}, {28'd0, prod_count}, {28'd0, exp_pc});
    endtask

    initial begin
        logic saw_we;
        reset_n = 1'b0;
        multi_opstart = 1'b0;
        multi_opclear = 1'b0;
        op_a = '0;
        op_b = '0;
        op_valid = 1'b0;
        fifo_full = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, op_ready}, 32'd0);
        check("rst_we", {31'd0, fifo_we}, 32'd0);
        check("rst_din", fifo_din, 32'd0);
        check("rst_pc", {28'd0, prod_count}, 32'd0);
        check("rst_done", {31'd0, multi_opdone}, 32'd0);

        reset_n = 1'b1;
        tick();
        check("idle_ready", {31'd0, op_ready}, 32'd0);
        multi_opstart = 1'b1;
        tick();
        check("load_ready", {31'd0, op_ready}, 32'd1);

        do_job("p3x5", 32'd3, 32'd5, 32'h0000000F, 4'd1);
        tick();
        check("we_pulse", {31'd0, fifo_we}, 32'd0);
        do_job("pmax", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 4'd2);
        do_job("p2_16", 32'h00010000, 32'h00010000, 32'h00000000, 4'd3);
        do_job("pzero", 32'd0, 32'h00001234, 32'h00000000, 4'd4);

        multi_opclear = 1'b1;
        tick();
        multi_opclear = 1'b0;
        check("clr_pc", {28'd0, prod_count}, 32'd0);
        check("clr_ready", {31'd0, op_ready}, 32'd0);

        for (int i = 1; i <= 8; i++)
            do_job($sformatf("sq%0d", i), 32'(i), 32'(i), 32'(i * i), 4'(i));
        check("done_set", {31'd0, multi_opdone}, 32'd1);
        check("done_ready", {31'd0, op_ready}, 32'd0);
        repeat (3) tick();
        check("done_hold", {31'd0, multi_opdone}, 32'd1);
        check("done_pc", {28'd0, prod_count}, 32'd8);
        check("done_we", {31'd0, fifo_we}, 32'd0);

        multi_opstart = 1'b0;
        tick();
        check("stop_done", {31'd0, multi_opdone}, 32'd0);
        check("stop_pc", {28'd0, prod_count}, 32'd0);

        // Backpressure: hold fifo_full across ten WRITE cycles.
        multi_opstart = 1'b1;
        fifo_full = 1'b1;
        wait_ready("full");
        accept(32'd7, 32'd9);
        saw_we = 1'b0;
        repeat (LAT - 1) begin
            tick();
            if (fifo_we) saw_we = 1'b1;
        end
        repeat (10) begin
            tick();
            if (fifo_we) saw_we = 1'b1;
        end
        check("full_no_we", {31'd0, saw_we}, 32'd0);
        check("full_din_old", fifo_din, 32'd64);
        fifo_full = 1'b0;
        tick();
        check("full_we", {31'd0, fifo_we}, 32'd1);
        check("full_din", fifo_din, 32'd63);
        check("full_pc", {28'd0, prod_count}, 32'd1);

        // Clear during the third product's calculation.
        do_job("c2", 32'd2, 32'd2, 32'd4, 4'd2);
        wait_ready("c3");
        accept(32'd5, 32'd5);
        repeat (5) tick();
        multi_opclear = 1'b1;
        tick();
        multi_opclear = 1'b0;
        check("mclr_pc", {28'd0, prod_count}, 32'd0);
        check("mclr_done", {31'd0, multi_opdone}, 32'd0);
        check("mclr_ready", {31'd0, op_ready}, 32'd0);
        check("mclr_we", {31'd0, fifo_we}, 32'd0);
        do_job("re6x7", 32'd6, 32'd7, 32'd42, 4'd1);

        // Reset during calculation.
        wait_ready("r");
        accept(32'd11, 32'd13);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mrst_din", fifo_din, 32'd0);
        check("mrst_pc", {28'd0, prod_count}, 32'd0);
        check("mrst_ready", {31'd0, op_ready}, 32'd0);
        check("mrst_we", {31'd0, fifo_we}, 32'd0);
        multi_opstart = 1'b0;
        tick();
        multi_opstart = 1'b1;
        do_job("r12x12", 32'd12, 32'd12, 32'd144, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_stage.md
MULTI_STAGE -- requirements
Module: multi_stage

Interface
REQ-001 SHALL have parameter N_PROD, default 8, meaning the number of products per job; the ADDER stage consumes exactly 8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port multi_opstart, input, 1 bit: job enable, level-sensitive.
REQ-005 SHALL have port multi_opclear, input, 1 bit: synchronous clear, shared with the ADDER stage.
REQ-006 SHALL have ports op_a and op_b, input, 32 bits each: multiplicand and multiplier.
REQ-007 SHALL have port op_valid, input, 1 bit: the operand pair is valid.
REQ-008 SHALL have port op_ready, output, 1 bit: the stage accepts a pair.
REQ-009 SHALL have port fifo_full, input, 1 bit: the downstream product FIFO is full.
REQ-010 SHALL have port fifo_we, output, 1 bit: FIFO write strobe.
REQ-011 SHALL have port fifo_din, output, 32 bits: product written to the FIFO.
REQ-012 SHALL have port prod_count, output, 4 bits: products written in the current job.
REQ-013 SHALL have port multi_opdone, output, 1 bit: the job is complete.

Function
REQ-014 SHALL implement states IDLE, LOAD, CALC, WRITE, DONE; all outputs registered.
REQ-015 SHALL, in IDLE with multi_opstart=1, move to LOAD on the next edge; otherwise it stays in IDLE.
REQ-016 SHALL drive op_ready=1 only in LOAD; an edge with op_valid&op_ready latches op_a/op_b, clears the 32-bit accumulator and the step counter, and moves to CALC.
REQ-017 SHALL perform in CALC unsigned radix-2 shift-add: if the multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^32); shift the multiplicand left 1; shift the multiplier right 1; 32 steps, then go to WRITE.
REQ-018 SHALL produce fifo_din = (op_a*op_b) mod 2^32; the upper 32 product bits are discarded.
REQ-019 SHALL stay in WRITE while fifo_full=1, with fifo_we=0 and no accumulator change.
REQ-020 SHALL, on the first WRITE edge with fifo_full=0, do all of: set fifo_we=1 for exactly one cycle; set fifo_din=accumulator; increment prod_count.
REQ-021 SHALL then go to DONE if the new prod_count equals N_PROD, else to LOAD.
REQ-022 SHALL assert fifo_we in the cycle following the 33rd rising edge after the accepting edge when fifo_full=0 (radix-2).
REQ-023 SHALL hold fifo_din until the next write.
REQ-024 SHALL set multi_opdone=1 on entry to DONE and hold it while multi_opstart=1; prod_count holds N_PROD.
REQ-025 SHALL, when multi_opstart=0 in any non-IDLE state, go to IDLE on the next edge and clear multi_opdone, op_ready, fifo_we and prod_count. FIFO entries already written remain.
REQ-026 SHALL give multi_opclear=1 priority over all other inputs except reset_n, with the same effect as REQ-025.
REQ-027 SHALL ignore op_valid outside LOAD.
REQ-028 SHALL treat op_valid and fifo_full as don't-care in CALC.
REQ-029 SHALL NOT wrap prod_count past N_PROD.
REQ-030 SHALL treat a zero operand normally (full step count, product 0); there is no early exit.

Reset
REQ-031 SHALL, on a clock edge with reset_n=0, enter IDLE with op_ready=0, fifo_we=0, fifo_din=0, prod_count=0, multi_opdone=0, and clear the accumulator, operands and step counter; this includes reset in mid-CALC or mid-WRITE.

Configuration
REQ-032 SHALL, with macro MULTI_RADIX4_EN defined, use radix-4 steps: add 0, 1x, 2x or 3x of the multiplicand per the two multiplier LSBs, and shift by 2.
REQ-033 SHALL, with MULTI_RADIX4_EN defined, run 16 CALC steps, so fifo_we asserts in the cycle following the 17th edge after acceptance.
REQ-034 SHALL, without MULTI_RADIX4_EN, use radix-2 steps with 32 CALC steps; fifo_din values SHALL be identical in both builds.

Verification
REQ-035 SHALL cover: start, op_a=3, op_b=5, fifo_full=0 -> fifo_we pulse with fifo_din=0x0000000F exactly 33 cycles after acceptance (17 with MULTI_RADIX4_EN).
REQ-036 SHALL cover: op_a=op_b=0xFFFFFFFF -> fifo_din=0x00000001; op_a=0x00010000, op_b=0x00010000 -> fifo_din=0x00000000.
REQ-037 SHALL cover: 8 back-to-back pairs (1*1..8*8) -> fifo_din sequence 1,4,9,...,64, prod_count 1..8, multi_opdone=1 after the 8th write, op_ready=0 thereafter.
REQ-038 SHALL cover: fifo_full=1 held 10 cycles while in WRITE -> no fifo_we; write occurs on the edge after fifo_full drops, with the value unchanged.
REQ-039 SHALL cover: multi_opclear=1 mid-CALC of the 3rd product -> next cycle IDLE, prod_count=0, multi_opdone=0; a restarted job produces correct products.
REQ-040 SHALL cover: reset_n=0 for one edge mid-CALC -> all outputs 0 and IDLE; multi_opstart low then high -> normal job.
